// File: rtl/i2c_xfer_seq_pkg.sv
// i2c_xfer_seq_pkg: i2c-master command/status encodings shared with the sequencer,
// plus the sequencer and step state types.
package i2c_xfer_seq_pkg;
    localparam int C_SZ = 6;
    localparam int S_SZ = 4;

    localparam int CB_STRT = 0;
    localparam int CB_STOP = 1;
    localparam int CB_READ = 2;
    localparam int CB_WRTE = 3;
    localparam int CB_NACK = 4;
    localparam int CB_CLRS = 5;

    localparam logic [C_SZ-1:0] C_STRT = C_SZ'(1) << CB_STRT;
    localparam logic [C_SZ-1:0] C_STOP = C_SZ'(1) << CB_STOP;
    localparam logic [C_SZ-1:0] C_READ = C_SZ'(1) << CB_READ;
    localparam logic [C_SZ-1:0] C_WRTE = C_SZ'(1) << CB_WRTE;
    localparam logic [C_SZ-1:0] C_NACK = C_SZ'(1) << CB_NACK;
    localparam logic [C_SZ-1:0] C_CLRS = C_SZ'(1) << CB_CLRS;

    localparam int SB_DON = 0;
    localparam int SB_ERR = 1;
    localparam int SB_BBY = 2;
    localparam int SB_LRA = 3;

    localparam logic [S_SZ-1:0] S_DON = S_SZ'(1) << SB_DON;
    localparam logic [S_SZ-1:0] S_ERR = S_SZ'(1) << SB_ERR;
    localparam logic [S_SZ-1:0] S_BBY = S_SZ'(1) << SB_BBY;
    localparam logic [S_SZ-1:0] S_LRA = S_SZ'(1) << SB_LRA;

    typedef enum logic [1:0] {SS_IDLE, SS_ISSUE, SS_ACK, SS_WAIT} step_state_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT, ST_WDAT, ST_CLR, ST_CLRW, ST_STOP, ST_STOPW, ST_FIN
    } seq_state_t;

    typedef enum logic [1:0] {P_ADDR, P_REG, P_RADDR, P_DATA} phase_t;

    function automatic logic [C_SZ-1:0] rd_cmd(input logic last);
        return last ? (C_READ | C_NACK | C_STOP) : C_READ;
    endfunction

    function automatic logic [C_SZ-1:0] wr_cmd(input logic last);
        return last ? (C_WRTE | C_STOP) : C_WRTE;
    endfunction
endpackage

// File: rtl/i2c_xfer_step.sv
// i2c_xfer_step: one master step (ISSUE -> ACK -> WAIT) with per-step timeout;
// reports done/err and the master status seen on error (0 on timeout).
module i2c_xfer_step
    import i2c_xfer_seq_pkg::*;
#(
    parameter int TO_CYC = 200000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_go,
    input  logic [C_SZ-1:0] i_cmd,
    input  logic [7:0]      i_dat,
    output logic [C_SZ-1:0] o_m_cmd,
    output logic [7:0]      o_m_dat,
    output logic            o_m_ws,
    input  logic [S_SZ-1:0] i_m_stat,
    output logic            o_done,
    output logic            o_err,
    output logic [S_SZ-1:0] o_stat
);
    localparam int TW = $clog2(TO_CYC + 1);

    step_state_t r_state;
    logic [TW-1:0] r_tmo;
    logic w_tmo, w_ok, w_end;

    assign w_tmo = (r_tmo == TW'(TO_CYC - 1));
    assign w_ok  = (r_state == SS_WAIT) && i_m_stat[SB_DON] && !i_m_stat[SB_ERR];
    assign w_end = i_m_stat[SB_ERR] || w_ok || w_tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SS_IDLE;
            r_tmo   <= '0;
            o_m_cmd <= '0;
            o_m_dat <= '0;
            o_m_ws  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_stat  <= '0;
        end else begin
            o_m_ws <= 1'b0;
            o_done <= 1'b0;
            case (r_state)
                SS_IDLE: if (i_go) begin
                    r_state <= SS_ISSUE;
                    o_m_cmd <= i_cmd;
                    o_m_dat <= i_dat;
                    o_m_ws  <= 1'b1;
                    r_tmo   <= '0;
                end
                SS_ISSUE: r_state <= SS_ACK;
                SS_ACK, SS_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    // a step that completes on its last allowed cycle counts as success
                    if (w_end) begin
                        r_state <= SS_IDLE;
                        o_done  <= 1'b1;
                        o_err   <= !w_ok;
                        o_stat  <= i_m_stat[SB_ERR] ? i_m_stat : '0;
                    end else if (r_state == SS_ACK && !i_m_stat[SB_DON]) begin
                        r_state <= SS_WAIT;
                    end
                end
                default: r_state <= SS_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: register-level transfer sequencer in front of i2c_master; turns one
// request into address/register/data steps and recovers from errors with CLRS then STOP.
module i2c_xfer_seq
    import i2c_xfer_seq_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int TO_CYC = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [6:0]       req_addr,
    input  logic             req_rd,
    input  logic [7:0]       req_reg,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wr_dat,
    input  logic             wr_vld,
    output logic             wr_rdy,
    output logic [7:0]       rd_dat,
    output logic             rd_vld,
    output logic             done,
    output logic             err,
    output logic [S_SZ-1:0]  err_stat,
    output logic [C_SZ-1:0]  m_cmd,
    output logic [7:0]       m_dat,
    output logic             m_ws,
    input  logic [S_SZ-1:0]  m_stat,
    input  logic [7:0]       m_dat_in
);
    seq_state_t       r_state;
    phase_t           r_phase;
    logic [6:0]       r_addr;
    logic             r_rd;
    logic [7:0]       r_reg;
    logic [LEN_W-1:0] r_cnt;
    logic [C_SZ-1:0]  r_cmd;
    logic [7:0]       r_dat;
    logic             r_req_rdy, r_fail, r_rd_vld;
    logic [7:0]       r_rd_dat;
    logic [S_SZ-1:0]  r_err_stat;
    logic             w_go, w_st_done, w_st_err, w_cnt0, w_cnt1, w_cnt2;
    logic [S_SZ-1:0]  w_st_stat;

    assign w_go   = r_state inside {ST_ISSUE, ST_CLR, ST_STOP};
    assign w_cnt0 = (r_cnt == '0);
    assign w_cnt1 = (r_cnt == LEN_W'(1));
    assign w_cnt2 = (r_cnt == LEN_W'(2));

    assign req_rdy  = r_req_rdy;
    assign wr_rdy   = (r_state == ST_WDAT) && wr_vld;
    assign rd_dat   = r_rd_dat;
    assign rd_vld   = r_rd_vld;
    assign done     = (r_state == ST_FIN);
    assign err      = (r_state == ST_FIN) && r_fail;
    assign err_stat = r_err_stat;

    i2c_xfer_step #(.TO_CYC(TO_CYC)) u_step (
        .clk      (clk),
        .rst      (rst),
        .i_go     (w_go),
        .i_cmd    (r_cmd),
        .i_dat    (r_dat),
        .o_m_cmd  (m_cmd),
        .o_m_dat  (m_dat),
        .o_m_ws   (m_ws),
        .i_m_stat (m_stat),
        .o_done   (w_st_done),
        .o_err    (w_st_err),
        .o_stat   (w_st_stat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= P_ADDR;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_reg      <= '0;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_dat      <= '0;
            r_req_rdy  <= 1'b1;
            r_fail     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_dat   <= '0;
            r_err_stat <= '0;
        end else begin
            r_rd_vld <= 1'b0;
            case (r_state)
                ST_IDLE: if (req_vld) begin
                    r_addr     <= req_addr;
                    r_rd       <= req_rd;
                    r_reg      <= req_reg;
                    r_cnt      <= req_len;
                    r_phase    <= P_ADDR;
                    r_cmd      <= C_STRT | C_WRTE;
                    r_dat      <= {req_addr, 1'b0};
                    r_req_rdy  <= 1'b0;
                    r_fail     <= 1'b0;
                    r_err_stat <= '0;
                    r_state    <= ST_ISSUE;
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: if (w_st_done) begin
                    if (w_st_err) begin
                        r_fail     <= 1'b1;
                        r_err_stat <= w_st_stat;
                        r_cmd      <= C_CLRS;
                        r_state    <= ST_CLR;
                    end else begin
                        case (r_phase)
                            P_ADDR: begin
                                r_phase <= P_REG;
                                r_cmd   <= wr_cmd(w_cnt0);
                                r_dat   <= r_reg;
                                r_state <= ST_ISSUE;
                            end
                            P_REG: begin
                                if (w_cnt0) begin
                                    r_state <= ST_FIN;
                                end else if (r_rd) begin
                                    r_phase <= P_RADDR;
                                    r_cmd   <= C_STRT | C_WRTE;
                                    r_dat   <= {r_addr, 1'b1};
                                    r_state <= ST_ISSUE;
                                end else begin
                                    r_phase <= P_DATA;
                                    r_state <= ST_WDAT;
                                end
                            end
                            P_RADDR: begin
                                r_phase <= P_DATA;
                                r_cmd   <= rd_cmd(w_cnt1);
                                r_dat   <= 8'h00;
                                r_state <= ST_ISSUE;
                            end
                            P_DATA: begin
                                r_cnt    <= r_cnt - 1'b1;
                                r_rd_vld <= r_rd;
                                if (r_rd) r_rd_dat <= m_dat_in;
                                if (w_cnt1) begin
                                    r_state <= ST_FIN;
                                end else if (r_rd) begin
                                    r_cmd   <= rd_cmd(w_cnt2);
                                    r_state <= ST_ISSUE;
                                end else begin
                                    r_state <= ST_WDAT;
                                end
                            end
                        endcase
                    end
                end
                ST_WDAT: if (wr_vld) begin
                    r_dat   <= wr_dat;
                    r_cmd   <= wr_cmd(w_cnt1);
                    r_state <= ST_ISSUE;
                end
                ST_CLR: r_state <= ST_CLRW;
                // an error while clearing is ignored; the first captured status stands
                ST_CLRW: if (w_st_done) begin
                    if (!w_st_err && m_stat[SB_BBY]) begin
                        r_cmd   <= C_STOP;
                        r_state <= ST_STOP;
                    end else begin
                        r_state <= ST_FIN;
                    end
                end
                ST_STOP:  r_state <= ST_STOPW;
                ST_STOPW: if (w_st_done) r_state <= ST_FIN;
                ST_FIN: begin
                    r_req_rdy <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb_i2c_xfer_seq: directed and random register transfers against a command-level
// i2c master + slave-RAM model; expectations come from a transfer-level reference.
`timescale 1ns/1ps
module tb_i2c_xfer_seq;
    import i2c_xfer_seq_pkg::*;

    localparam int TO = 200;
    localparam logic [6:0] SLV = 7'h3a;

    typedef struct packed {
        logic [C_SZ-1:0] cmd;
        logic [7:0]      dat;
        logic            cd;
    } step_t;

    logic clk = 1'b0, rst = 1'b1;
    logic req_vld = 1'b0, req_rd = 1'b0, wr_vld = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_reg = '0, req_len = '0, wr_dat = '0;
    logic req_rdy, wr_rdy, rd_vld, done, err, m_ws;
    logic [7:0] rd_dat, m_dat, m_dat_in;
    logic [S_SZ-1:0] err_stat, m_stat;
    logic [C_SZ-1:0] m_cmd;

    always #5 clk = ~clk;

    i2c_xfer_seq #(.LEN_W(8), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_rd(req_rd), .req_reg(req_reg), .req_len(req_len), .wr_dat(wr_dat),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .rd_dat(rd_dat), .rd_vld(rd_vld), .done(done),
        .err(err), .err_stat(err_stat), .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws),
        .m_stat(m_stat), .m_dat_in(m_dat_in)
    );

    // command-level master with one slave RAM at SLV; hang freezes the current command
    logic [7:0] smem [256];
    logic minit = 1'b0, pend = 1'b0, hang = 1'b0, pset = 1'b0;
    logic don = 1'b0, errb = 1'b0, bby = 1'b0, lra = 1'b0;
    logic [C_SZ-1:0] pcmd = '0;
    logic [7:0] pdat = '0, ptr = '0, dout = '0;
    int tmr = 0;

    assign m_stat[SB_DON] = don;
    assign m_stat[SB_ERR] = errb;
    assign m_stat[SB_BBY] = bby;
    assign m_stat[SB_LRA] = lra;
    assign m_dat_in = dout;

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0; don <= 1'b0; errb <= 1'b0; bby <= 1'b0; lra <= 1'b0;
            dout <= '0; pset <= 1'b0; ptr <= '0;
            if (!minit) for (int i = 0; i < 256; i++) smem[i] <= 8'(i) ^ 8'h5a;
            minit <= 1'b1;
        end else if (m_ws) begin
            pend <= 1'b1; pcmd <= m_cmd; pdat <= m_dat; don <= 1'b0; errb <= 1'b0;
            tmr <= int'($urandom_range(0, 3));
        end else if (pend && !hang) begin
            if (tmr != 0) tmr <= tmr - 1;
            else begin
                pend <= 1'b0;
                don  <= 1'b1;
                if (pcmd[CB_CLRS]) lra <= 1'b0;
                else if (pcmd[CB_STRT]) begin
                    bby <= 1'b1;
                    if (pdat[7:1] != SLV) begin errb <= 1'b1; lra <= 1'b1; don <= 1'b0; end
                    else if (!pdat[0]) pset <= 1'b0;
                end else if (pcmd[CB_WRTE]) begin
                    if (!pset) begin ptr <= pdat; pset <= 1'b1; end
                    else begin smem[ptr] <= pdat; ptr <= ptr + 8'd1; end
                end else if (pcmd[CB_READ]) begin
                    dout <= smem[ptr]; ptr <= ptr + 8'd1;
                end
                if (pcmd[CB_STOP]) bby <= 1'b0;
            end
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [7:0] ref_mem [256];
    step_t expq[$];
    logic [7:0] rdq[$], wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic step_t mk(input logic [C_SZ-1:0] c, input logic [7:0] d, input logic cd);
        step_t s;
        s.cmd = c; s.dat = d; s.cd = cd;
        return s;
    endfunction

    task automatic do_req(input logic [6:0] a, input logic rd, input logic [7:0] rg,
                          input int len, input int rst_at, input bit fixed);
        step_t s;
        int wr_n = 0, rd_n = 0, cyc = 0, exp_wr = 0;
        bit fin = 0;
        logic exp_err;
        logic [S_SZ-1:0] exp_stat;
        logic [31:0] e;
        expq.delete(); rdq.delete(); wq.delete();
        if (!rd) for (int i = 0; i < len; i++) wq.push_back(fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        expq.push_back(mk(C_STRT | C_WRTE, {a, 1'b0}, 1'b1));
        exp_err = 1'b1;
        exp_stat = '0;
        if (hang) expq.push_back(mk(C_CLRS, 8'h00, 1'b0));
        else if (a != SLV) begin
            expq.push_back(mk(C_CLRS, 8'h00, 1'b0));
            expq.push_back(mk(C_STOP, 8'h00, 1'b0));
            exp_stat = S_ERR | S_BBY | S_LRA;
        end else begin
            exp_err = 1'b0;
            exp_wr = rd ? 0 : len;
            expq.push_back(mk((len == 0) ? (C_WRTE | C_STOP) : C_WRTE, rg, 1'b1));
            if (rd && len > 0) expq.push_back(mk(C_STRT | C_WRTE, {a, 1'b1}, 1'b1));
            for (int i = 0; i < len; i++) begin
                if (rd) begin
                    expq.push_back(mk((i == len - 1) ? (C_READ | C_NACK | C_STOP) : C_READ, 8'h00, 1'b0));
                    rdq.push_back(ref_mem[8'(int'(rg) + i)]);
                end else begin
                    expq.push_back(mk((i == len - 1) ? (C_WRTE | C_STOP) : C_WRTE, wq[i], 1'b1));
                    ref_mem[8'(int'(rg) + i)] = wq[i];
                end
            end
        end
        @(posedge clk); #1;
        chk("req_rdy_idle", req_rdy, 1);
        req_vld = 1'b1; req_addr = a; req_rd = rd; req_reg = rg; req_len = 8'(len);
        @(posedge clk); #1;
        req_vld = 1'b0; req_addr = 7'($urandom); req_rd = 1'($urandom); req_reg = 8'($urandom);
        while (!fin) begin
            wr_vld = (wq.size() > 0) && ($urandom_range(0, 2) != 0);
            wr_dat = wr_vld ? wq[0] : 8'($urandom);
            @(negedge clk);
            if (wr_rdy) begin
                wr_n++;
                if (wq.size() > 0) void'(wq.pop_front());
            end
            if (m_ws) begin
                s = (expq.size() > 0) ? expq.pop_front() : mk('1, 8'hff, 1'b1);
                chk("m_cmd", m_cmd, s.cmd);
                if (s.cd) chk("m_dat", m_dat, s.dat);
            end
            if (rd_vld) begin
                rd_n++;
                e = (rdq.size() > 0) ? 32'(rdq.pop_front()) : 32'h1ff;
                chk("rd_dat", rd_dat, e);
            end
            if (rst_at != 0 && rd_n == rst_at) begin
                wr_vld = 1'b0;
                @(posedge clk); #1; rst = 1'b1;
                @(posedge clk); #1; rst = 1'b0;
                @(negedge clk);
                chk("rst_req_rdy", req_rdy, 1);
                chk("rst_done", done, 0);
                chk("rst_rd_vld", rd_vld, 0);
                chk("rst_m_ws", m_ws, 0);
                return;
            end
            if (done) begin
                chk("err", err, exp_err);
                chk("err_stat", err_stat, exp_stat);
                chk("req_rdy_in_done", req_rdy, 0);
                fin = 1;
            end else if (++cyc > 20000) begin
                chk("done_within_budget", done, 1);
                fin = 1;
            end
            if (!fin) begin @(posedge clk); #1; end
        end
        wr_vld = 1'b0;
        chk("steps_left", expq.size(), 0);
        chk("rd_left", rdq.size(), 0);
        chk("wr_cnt", wr_n, exp_wr);
        @(negedge clk);
        chk("req_rdy_after_done", req_rdy, 1);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5a;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_stat", err_stat, 0);
        chk("rst_m_ws", m_ws, 0);
        chk("rst_m_cmd", m_cmd, 0);
        chk("rst_m_dat", m_dat, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_wr_rdy", wr_rdy, 0);
        @(posedge clk); #1; rst = 1'b0;

        do_req(SLV, 1'b0, 8'h00, 8, 0, 1'b1);
        do_req(SLV, 1'b1, 8'h00, 8, 0, 1'b0);
        do_req(7'h3c, 1'b0, 8'h10, 2, 0, 1'b0);
        do_req(SLV, 1'b0, 8'h40, 3, 0, 1'b0);
        do_req(SLV, 1'b0, 8'h05, 0, 0, 1'b0);
        chk("ref_idx5", ref_mem[5], 8'h66);
        do_req(SLV, 1'b1, 8'h05, 1, 0, 1'b0);
        do_req(SLV, 1'b1, 8'h00, 8, 4, 1'b0);
        do_req(SLV, 1'b1, 8'h00, 3, 0, 1'b0);

        hang = 1'b1;
        do_req(SLV, 1'b0, 8'h20, 1, 0, 1'b0);
        hang = 1'b0;
        repeat (6) @(posedge clk);
        do_req(SLV, 1'b1, 8'h00, 2, 0, 1'b0);

        for (int k = 0; k < 16; k++)
            do_req(($urandom_range(0, 6) == 0) ? 7'h3c : SLV, 1'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)), 0, 1'b0);

        do_req(SLV, 1'b0, 8'h80, 255, 0, 1'b0);
        do_req(SLV, 1'b1, 8'h80, 255, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
